alu_mul_sequencer: RTL and testbench

Multi-cycle unsigned 32x32 -> 64-bit multiplier that drives the 32-bit ALU as its initiator. It issues one ADD command per cycle on the ALU operand/command port and reads back `result`/`carryout` in the same cycle, which is valid because the ALU is combinational. It implements radix-2 shift-and-add, one multiplier bit per cycle. It sits beside the ALU in the datapath, and the ALU needs no extra hardware.

---
 rtl/alu_mul_sequencer.sv | 89 ++++++++
 tb/tb_alu_mul_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - radix-2 shift-and-add 32x32->64 multiplier that borrows an external combinational ALU
module alu_mul_sequencer #(
   parameter logic [2:0] ADD_COMMAND = 3'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] multiplicand,
   input  logic [31:0] multiplier,
   output logic        busy,
   output logic        done,
   output logic [63:0] product,
   output logic [31:0] alu_operand_a,
   output logic [31:0] alu_operand_b,
   output logic [2:0]  alu_command,
   input  logic [31:0] alu_result,
   input  logic        alu_carryout
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e      state_q;
   logic [31:0] mcand_q;
   logic [31:0] acc_hi_q;
   logic [31:0] acc_lo_q;
   logic [4:0]  count_q;
   logic [63:0] product_q;
   logic        busy_q;
   logic        done_q;
   logic [63:0] step_d;

   // The ALU carry becomes bit 63 of the shifted accumulator, so the partial sum never loses a bit.
   assign step_d = {alu_carryout, alu_result, acc_lo_q[31:1]};

   assign alu_command   = ADD_COMMAND;
   assign alu_operand_a = acc_hi_q;
   assign alu_operand_b = acc_lo_q[0] ? mcand_q : 32'd0;

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         mcand_q   <= 32'd0;
         acc_hi_q  <= 32'd0;
         acc_lo_q  <= 32'd0;
         count_q   <= 5'd0;
         product_q <= 64'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  mcand_q  <= multiplicand;
                  acc_hi_q <= 32'd0;
                  acc_lo_q <= multiplier;
                  count_q  <= 5'd0;
                  busy_q   <= 1'b1;
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               {acc_hi_q, acc_lo_q} <= step_d;
               count_q              <= count_q + 5'd1;
               if (count_q == 5'd31) begin
                  product_q <= step_d;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - scoreboard bench for alu_mul_sequencer with a behavioural 32-bit adder as the ALU
module tb_alu_mul_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        busy;
   logic        done;
   logic [63:0] product;
   logic [31:0] alu_operand_a;
   logic [31:0] alu_operand_b;
   logic [2:0]  alu_command;
   logic [31:0] alu_result;
   logic        alu_carryout;
   logic [32:0] alu_sum;

   alu_mul_sequencer #(.ADD_COMMAND(3'd0)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .multiplicand  (multiplicand),
      .multiplier    (multiplier),
      .busy          (busy),
      .done          (done),
      .product       (product),
      .alu_operand_a (alu_operand_a),
      .alu_operand_b (alu_operand_b),
      .alu_command   (alu_command),
      .alu_result    (alu_result),
      .alu_carryout  (alu_carryout)
   );

   assign alu_sum      = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
   assign alu_result   = alu_sum[31:0];
   assign alu_carryout = alu_sum[32];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   int carry_seen = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (busy && !done && alu_carryout) carry_seen <= carry_seen + 1;

   typedef struct {
      logic [63:0] prod;
      int          cyc;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   done_seen  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_done: got done=1 with product %h expected no pending result", product);
            end else begin
               e = sb.pop_front();
               check({e.name, "_product"}, product, e.prod);
               check({e.name, "_busy_in_done"}, {63'd0, busy}, 64'd1);
               check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
               @(negedge clk);
               check({e.name, "_busy_fall"}, {62'd0, busy, done}, 64'd0);
            end
         end
      end
   end

   task automatic do_start(input logic [31:0] m, input logic [31:0] q, input bit push,
                           input logic [63:0] prod, input string name, output int acc);
      @(negedge clk);
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      @(posedge clk);
      #1;
      acc   = cyc;
      start = 1'b0;
      if (push) sb.push_back('{prod, acc + 32, name});
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      if (n >= 200) begin
         compared++;
         mismatched++;
         $display("FAIL wait_idle_timeout: got %0d pending results expected 0", sb.size());
      end
   endtask

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: got no finish after 20000 cycles expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int c0;
      int d0;
      logic bad;
      reset_n      = 1'b0;
      start        = 1'b0;
      multiplicand = 32'd0;
      multiplier   = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_product", product, 64'd0);
      check("rst_op_a", {32'd0, alu_operand_a}, 64'd0);
      check("rst_op_b", {32'd0, alu_operand_b}, 64'd0);
      check("rst_cmd", {61'd0, alu_command}, 64'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      do_start(32'd3, 32'd5, 1'b1, 64'd15, "basic", acc);
      @(negedge clk);
      check("basic_busy_rise", {63'd0, busy}, 64'd1);
      wait_idle();
      for (int i = 0; i < 10; i++) begin
         check("basic_hold", product, 64'd15);
         @(negedge clk);
      end

      c0 = carry_seen;
      do_start(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE_00000001, "carry", acc);
      wait_idle();
      check("carry_observed", {63'd0, (carry_seen > c0)}, 64'd1);

      do_start(32'h12345678, 32'd0, 1'b1, 64'd0, "zero", acc);
      bad = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (alu_operand_b !== 32'd0 || alu_command !== 3'd0) bad = 1'b1;
      end
      check("zero_alu_drive", {63'd0, bad}, 64'd0);
      wait_idle();
      for (int i = 0; i < 10; i++) begin
         check("zero_hold", product, 64'd0);
         @(negedge clk);
      end

      do_start(32'd7, 32'd9, 1'b1, 64'd63, "ignored", acc);
      repeat (10) @(negedge clk);
      multiplicand = 32'd2;
      multiplier   = 32'd2;
      start        = 1'b1;
      repeat (5) @(negedge clk);
      start = 1'b0;
      wait_idle();

      do_start(32'd100, 32'd100, 1'b0, 64'd0, "abort", acc);
      repeat (11) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_product", product, 64'd0);
      check("abort_op_a", {32'd0, alu_operand_a}, 64'd0);
      check("abort_op_b", {32'd0, alu_operand_b}, 64'd0);
      d0 = done_seen;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_no_done", 64'(done_seen), 64'(d0));
      do_start(32'd100, 32'd100, 1'b1, 64'd10000, "after_reset", acc);
      wait_idle();

      @(negedge clk);
      multiplicand = 32'h80000000;
      multiplier   = 32'd2;
      start        = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      sb.push_back('{64'h1_00000000, acc + 32, "b2b_first"});
      sb.push_back('{64'h0_FFFFFFFF, acc + 34 + 32, "b2b_second"});
      multiplicand = 32'd65535;
      multiplier   = 32'd65537;
      repeat (34) @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle();

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
